add_sub_checker: RTL and testbench

ADD_SUB_CHECKER -- requirements
Module: add_sub_checker

---
 rtl/add_sub_checker.sv | 248 ++++++++++++++++++++++++
 tb/tb_add_sub_checker.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_checker.sv
// add_sub_checker: checks results of an 8-bit two's-complement adder/subtractor.
// A run begins with a start pulse and accepts num_vec vectors. Each vector goes
// through a two-stage pipeline: stage 1 computes the expected result and flags,
// and stage 2 compares them and updates the pass/fail counters.
// Build option: define ADD_SUB_CHECKER_FAIL_LOG_EN to capture the first failing
// vector on fail_a/fail_b/fail_c. Without it those outputs are tied to 0.
module add_sub_checker (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] num_vec,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        sub,
    input  logic [7:0]  c,
    input  logic        zero,
    input  logic        overflow,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        err,
    output logic [15:0] pass_cnt,
    output logic [15:0] fail_cnt,
    output logic [7:0]  fail_a,
    output logic [7:0]  fail_b,
    output logic [7:0]  fail_c
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_t;

    localparam logic [15:0] CntMax = 16'hFFFF;

    // Run control state
    state_t      r_state;
    logic [15:0] r_num_vec;
    logic [15:0] r_acc_cnt;
    logic        r_drain_cnt;
    logic        r_in_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;

    // Result state
    logic        r_err;
    logic [15:0] r_pass_cnt;
    logic [15:0] r_fail_cnt;

    // Stage 1 pipeline registers
    logic        r_s1_valid;
    logic [7:0]  r_s1_c;
    logic        r_s1_zero;
    logic        r_s1_ovf;
    logic [7:0]  r_s1_sum;
    logic        r_s1_exp_zero;
    logic        r_s1_exp_ovf;

    // Combinational helpers
    logic        w_accept;
    logic        w_start_ok;
    logic [15:0] w_acc_inc;
    logic [7:0]  w_bb;
    logic [7:0]  w_sum;
    logic        w_exp_zero;
    logic        w_exp_ovf;
    logic        w_s2_diff;
    logic        w_match;
    logic        w_mismatch;

    // Handshake and start qualification; in_ready is already zero outside RUN
    always_comb begin
        w_accept   = in_valid && r_in_ready;
        w_start_ok = start && ((r_state == StIdle) || (r_state == StDone));
        w_acc_inc  = r_acc_cnt + {15'd0, w_accept};
    end

    // Stage 1 expected-value computation: subtraction is a + ~b + 1
    always_comb begin
        w_bb       = sub ? ~b : b;
        w_sum      = a + w_bb + {7'd0, sub};
        w_exp_zero = (w_sum == 8'd0);
        w_exp_ovf  = (a[7] == w_bb[7]) && (w_sum[7] != a[7]);
    end

    // Stage 1 register: capture the accepted vector with its expected values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_c        <= 8'd0;
            r_s1_zero     <= 1'b0;
            r_s1_ovf      <= 1'b0;
            r_s1_sum      <= 8'd0;
            r_s1_exp_zero <= 1'b0;
            r_s1_exp_ovf  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_c        <= c;
                r_s1_zero     <= zero;
                r_s1_ovf      <= overflow;
                r_s1_sum      <= w_sum;
                r_s1_exp_zero <= w_exp_zero;
                r_s1_exp_ovf  <= w_exp_ovf;
            end
        end
    end

    // Stage 2 compare of received result and flags against expected values
    always_comb begin
        w_s2_diff  = (r_s1_c != r_s1_sum) || (r_s1_zero != r_s1_exp_zero) ||
                     (r_s1_ovf != r_s1_exp_ovf);
        w_match    = r_s1_valid && !w_s2_diff;
        w_mismatch = r_s1_valid && w_s2_diff;
    end

    // Stage 2 counters and sticky error; counters saturate instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass_cnt <= 16'd0;
            r_fail_cnt <= 16'd0;
            r_err      <= 1'b0;
        end else if (w_start_ok) begin
            r_pass_cnt <= 16'd0;
            r_fail_cnt <= 16'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_match && (r_pass_cnt != CntMax)) begin
                r_pass_cnt <= r_pass_cnt + 16'd1;
            end
            if (w_mismatch) begin
                r_err <= 1'b1;
                if (r_fail_cnt != CntMax) begin
                    r_fail_cnt <= r_fail_cnt + 16'd1;
                end
            end
        end
    end

    // Run FSM with registered in_ready/busy/done/pass
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_num_vec   <= 16'd0;
            r_acc_cnt   <= 16'd0;
            r_drain_cnt <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state    <= StRun;
                        r_num_vec  <= num_vec;
                        r_acc_cnt  <= 16'd0;
                        r_in_ready <= (num_vec != 16'd0);
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                    end
                end
                StRun: begin
                    r_acc_cnt <= w_acc_inc;
                    // Leave RUN on the edge that accepts the last vector, so an
                    // empty run spends exactly one cycle here
                    if (w_acc_inc >= r_num_vec) begin
                        r_state     <= StDrain;
                        r_in_ready  <= 1'b0;
                        r_drain_cnt <= 1'b0;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                StDrain: begin
                    // Two cycles let the last vector reach the counters before
                    // pass is sampled
                    if (r_drain_cnt) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_fail_cnt == 16'd0);
                    end else begin
                        r_drain_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

`ifdef ADD_SUB_CHECKER_FAIL_LOG_EN
    logic [7:0] r_s1_a;
    logic [7:0] r_s1_b;
    logic [7:0] r_fail_a;
    logic [7:0] r_fail_b;
    logic [7:0] r_fail_c;

    // Operand copies travel alongside stage 1 only for first-failure capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_a <= 8'd0;
            r_s1_b <= 8'd0;
        end else if (w_accept) begin
            r_s1_a <= a;
            r_s1_b <= b;
        end
    end

    // Capture the first mismatching vector; err still clear marks "first"
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_fail_a <= 8'd0;
            r_fail_b <= 8'd0;
            r_fail_c <= 8'd0;
        end else if (w_mismatch && !r_err) begin
            r_fail_a <= r_s1_a;
            r_fail_b <= r_s1_b;
            r_fail_c <= r_s1_c;
        end
    end

    assign fail_a = r_fail_a;
    assign fail_b = r_fail_b;
    assign fail_c = r_fail_c;
`else
    assign fail_a = 8'd0;
    assign fail_b = 8'd0;
    assign fail_c = 8'd0;
`endif

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err      = r_err;
    assign pass_cnt = r_pass_cnt;
    assign fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_add_sub_checker.sv
// Directed testbench for add_sub_checker. Expected values are hand-computed.
// Honours ADD_SUB_CHECKER_FAIL_LOG_EN for the fail_a/fail_b/fail_c expectations.
module tb_add_sub_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_vec;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sub;
    logic [7:0]  c;
    logic        zero;
    logic        overflow;
    logic        busy;
    logic        done;
    logic        pass;
    logic        err;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
    logic [7:0]  fail_a;
    logic [7:0]  fail_b;
    logic [7:0]  fail_c;

    int n_applied = 0;
    int n_miscmp  = 0;

    logic [7:0] v_a   [16];
    logic [7:0] v_b   [16];
    logic       v_sub [16];
    logic [7:0] v_c   [16];
    logic       v_zero[16];
    logic       v_ovf [16];

    add_sub_checker dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_vec  (num_vec),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .c        (c),
        .zero     (zero),
        .overflow (overflow),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err      (err),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .fail_a   (fail_a),
        .fail_b   (fail_b),
        .fail_c   (fail_c)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [7:0] va, input logic [7:0] vb,
                        input logic vs, input logic [7:0] vc, input logic vz,
                        input logic vo);
        v_a[i] = va; v_b[i] = vb; v_sub[i] = vs;
        v_c[i] = vc; v_zero[i] = vz; v_ovf[i] = vo;
    endtask

    task automatic set_vec(input int i);
        a = v_a[i]; b = v_b[i]; sub = v_sub[i];
        c = v_c[i]; zero = v_zero[i]; overflow = v_ovf[i];
    endtask

    // Start a run, feed nsend loaded vectors, wait (bounded) for done
    task automatic do_run(input int num, input int nsend, output bit timed_out);
        int guard;
        timed_out = 1'b0;
        start = 1'b1;
        num_vec = num[15:0];
        tick();
        start = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            set_vec(i);
            in_valid = 1'b1;
            guard = 0;
            while (!in_ready && guard < 20) begin
                tick();
                guard++;
            end
            if (guard >= 20) timed_out = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !done; k++) tick();
        if (!done) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; num_vec = 16'd3;
        a = 8'd1; b = 8'd1; sub = 1'b0; c = 8'd2; zero = 1'b0; overflow = 1'b0;
        tick();
        tick();
        n_applied++;
        if ({in_ready, busy, done, pass, err} !== 5'b0) begin
            n_miscmp++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {in_ready, busy, done, pass, err});
        end
        n_applied++;
        if ({pass_cnt, fail_cnt} !== 32'd0) begin
            n_miscmp++;
            $display("FAIL reset_counts: got pass=%0d fail=%0d expected 0/0",
                     pass_cnt, fail_cnt);
        end
        n_applied++;
        if ({fail_a, fail_b, fail_c} !== 24'd0) begin
            n_miscmp++;
            $display("FAIL reset_fail_log: got %h expected 0", {fail_a, fail_b, fail_c});
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        tick();
        n_applied++;
        if (busy !== 1'b0 || pass_cnt !== 16'd0) begin
            n_miscmp++;
            $display("FAIL idle_ignores_valid: got busy=%b pass_cnt=%0d expected 0/0",
                     busy, pass_cnt);
        end
    endtask

    task automatic test_single();
        bit to;
        load(0, 8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 1'b0);
        do_run(1, 1, to);
        n_applied++;
        if (to !== 1'b0) begin
            n_miscmp++;
            $display("FAIL single_timeout: got timeout=%b expected 0", to);
        end
        n_applied++;
        if ({done, pass, err} !== 3'b110) begin
            n_miscmp++;
            $display("FAIL single_flags: got done/pass/err=%b expected 110", {done, pass, err});
        end
        n_applied++;
        if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin
            n_miscmp++;
            $display("FAIL single_counts: got pass=%0d fail=%0d expected 1/0",
                     pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_add_mix();
        bit to;
        load(0, 8'd100, 8'd100, 1'b0, 8'hC8, 1'b0, 1'b1);
        load(1, 8'd10, 8'hFB, 1'b0, 8'd5, 1'b0, 1'b0);
        load(2, 8'hFD, 8'hFC, 1'b0, 8'hF9, 1'b0, 1'b0);
        do_run(3, 3, to);
        n_applied++;
        if (to !== 1'b0 || pass_cnt !== 16'd3 || fail_cnt !== 16'd0 || pass !== 1'b1) begin
            n_miscmp++;
            $display("FAIL add_mix: got to=%b pass_cnt=%0d fail_cnt=%0d pass=%b expected 0/3/0/1",
                     to, pass_cnt, fail_cnt, pass);
        end
    endtask

    task automatic test_ovf_edges();
        bit to;
        load(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1); // 127+1 overflows
        load(1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1); // -128-1 overflows
        load(2, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0); // 0-0 = 0
        load(3, 8'd50, 8'd50, 1'b0, 8'd100, 1'b0, 1'b1); // bad overflow flag
        load(4, 8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0); // -128-(-128) = 0
        do_run(5, 5, to);
        n_applied++;
        if (to !== 1'b0 || pass_cnt !== 16'd4 || fail_cnt !== 16'd1) begin
            n_miscmp++;
            $display("FAIL ovf_counts: got to=%b pass=%0d fail=%0d expected 0/4/1",
                     to, pass_cnt, fail_cnt);
        end
        n_applied++;
        if ({pass, err} !== 2'b01) begin
            n_miscmp++;
            $display("FAIL ovf_flags: got pass/err=%b expected 01", {pass, err});
        end
`ifdef ADD_SUB_CHECKER_FAIL_LOG_EN
        n_applied++;
        if ({fail_a, fail_b, fail_c} !== {8'd50, 8'd50, 8'd100}) begin
            n_miscmp++;
            $display("FAIL ovf_fail_log: got %h expected 323264", {fail_a, fail_b, fail_c});
        end
`endif
    endtask

    task automatic test_zero_flag();
        bit to;
        load(0, 8'd5, 8'd5, 1'b1, 8'd0, 1'b1, 1'b0);
        do_run(1, 1, to);
        n_applied++;
        if (to !== 1'b0 || pass_cnt !== 16'd1 || fail_cnt !== 16'd0 || err !== 1'b0) begin
            n_miscmp++;
            $display("FAIL zero_good: got to=%b pass=%0d fail=%0d err=%b expected 0/1/0/0",
                     to, pass_cnt, fail_cnt, err);
        end
        load(0, 8'd5, 8'd5, 1'b1, 8'd0, 1'b0, 1'b0);
        do_run(1, 1, to);
        n_applied++;
        if (to !== 1'b0 || pass_cnt !== 16'd0 || fail_cnt !== 16'd1 || err !== 1'b1 ||
            pass !== 1'b0) begin
            n_miscmp++;
            $display("FAIL zero_bad: got to=%b pass=%0d fail=%0d err=%b pass=%b expected 0/0/1/1/0",
                     to, pass_cnt, fail_cnt, err, pass);
        end
    endtask

    task automatic test_fail_log();
        bit to;
        load(0, 8'd1, 8'd1, 1'b0, 8'd3, 1'b0, 1'b0);
        load(1, 8'd2, 8'd2, 1'b0, 8'd9, 1'b0, 1'b0);
        do_run(2, 2, to);
        n_applied++;
        if (to !== 1'b0 || fail_cnt !== 16'd2 || pass_cnt !== 16'd0 || pass !== 1'b0) begin
            n_miscmp++;
            $display("FAIL fail_counts: got to=%b fail=%0d pass_cnt=%0d pass=%b expected 0/2/0/0",
                     to, fail_cnt, pass_cnt, pass);
        end
        n_applied++;
`ifdef ADD_SUB_CHECKER_FAIL_LOG_EN
        if ({fail_a, fail_b, fail_c} !== {8'd1, 8'd1, 8'd3}) begin
`else
        if ({fail_a, fail_b, fail_c} !== 24'd0) begin
`endif
            n_miscmp++;
            $display("FAIL fail_log: got a=%0d b=%0d c=%0d", fail_a, fail_b, fail_c);
        end
    endtask

    task automatic test_num_zero();
        logic [2:0] seen [4];
        start = 1'b1; num_vec = 16'd0;
        tick();
        start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            seen[j] = {busy, in_ready, done};
            if (j < 3) tick();
        end
        n_applied++;
        if (seen[0] !== 3'b100 || seen[1] !== 3'b100 || seen[2] !== 3'b100 ||
            seen[3] !== 3'b001) begin
            n_miscmp++;
            $display("FAIL num_zero_seq: got %b %b %b %b expected 100 100 100 001",
                     seen[0], seen[1], seen[2], seen[3]);
        end
        n_applied++;
        if (pass !== 1'b1 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || err !== 1'b0) begin
            n_miscmp++;
            $display("FAIL num_zero_result: got pass=%b pcnt=%0d fcnt=%0d err=%b expected 1/0/0/0",
                     pass, pass_cnt, fail_cnt, err);
        end
        tick();
        tick();
        n_applied++;
        if (done !== 1'b1) begin
            n_miscmp++;
            $display("FAIL done_hold: got done=%b expected 1", done);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int last = -1;
        int done_at = -1;
        logic [15:0] pc1 = 16'hDEAD;
        logic [15:0] pc2 = 16'hDEAD;
        load(0, 8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 1'b0);
        start = 1'b1; num_vec = 16'd4;
        tick();
        start = 1'b0;
        set_vec(0);
        in_valid = 1'b1;
        for (int j = 0; j < 10; j++) begin
            if (done && done_at < 0) done_at = j;
            if (j == 1) pc1 = pass_cnt;
            if (j == 2) pc2 = pass_cnt;
            if (in_valid && in_ready) begin
                acc++;
                if (acc == 4) last = j;
            end
            start = (j == 1);
            tick();
        end
        start = 1'b0;
        in_valid = 1'b0;
        n_applied++;
        if (acc !== 4 || last !== 3) begin
            n_miscmp++;
            $display("FAIL b2b_accepts: got acc=%0d last=%0d expected 4/3", acc, last);
        end
        n_applied++;
        if (done_at !== last + 3) begin
            n_miscmp++;
            $display("FAIL b2b_done_timing: got %0d expected %0d", done_at, last + 3);
        end
        n_applied++;
        if (pc1 !== 16'd0 || pc2 !== 16'd1) begin
            n_miscmp++;
            $display("FAIL b2b_latency: got %0d,%0d expected 0,1", pc1, pc2);
        end
        n_applied++;
        if (pass_cnt !== 16'd4 || fail_cnt !== 16'd0 || pass !== 1'b1) begin
            n_miscmp++;
            $display("FAIL b2b_result: got pcnt=%0d fcnt=%0d pass=%b expected 4/0/1",
                     pass_cnt, fail_cnt, pass);
        end
    endtask

    task automatic test_reset_midrun();
        load(0, 8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 1'b0);
        start = 1'b1; num_vec = 16'd4;
        tick();
        start = 1'b0;
        set_vec(0);
        in_valid = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        n_applied++;
        if ({in_ready, busy, done, pass, err} !== 5'b0 || pass_cnt !== 16'd0 ||
            fail_cnt !== 16'd0 || {fail_a, fail_b, fail_c} !== 24'd0) begin
            n_miscmp++;
            $display("FAIL midrun_reset: got flags=%b pcnt=%0d fcnt=%0d log=%h expected all 0",
                     {in_ready, busy, done, pass, err}, pass_cnt, fail_cnt,
                     {fail_a, fail_b, fail_c});
        end
        rst = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_applied++;
        if ({in_ready, busy, done} !== 3'b0 || pass_cnt !== 16'd0) begin
            n_miscmp++;
            $display("FAIL midrun_after: got flags=%b pcnt=%0d expected 000/0",
                     {in_ready, busy, done}, pass_cnt);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; num_vec = 16'd0;
        a = 8'd0; b = 8'd0; sub = 1'b0; c = 8'd0; zero = 1'b0; overflow = 1'b0;
        tick();
        test_reset();
        test_single();
        test_add_mix();
        test_ovf_edges();
        test_zero_flag();
        test_fail_log();
        test_num_zero();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
        $finish;
    end

endmodule
